// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types, funct3 encodings and access-checking / store-steering helpers
// for the load/store unit and its load extraction datapath.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // funct3 access size / signedness encodings.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal encodings: loads accept signed and unsigned sizes, stores only B/H/W.
    function automatic logic access_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic bad;
        case (f3)
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = (addr_lo != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte-write enables for a store of the given size at the given lane.
    function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (f3)
            F3_B:    strb = 4'b0001 << addr_lo;
            F3_H:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Replicate the right-aligned store data across every lane it could target,
    // so the strobes alone pick the written bytes.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] data;
        case (f3)
            F3_B:    data = {4{wd[7:0]}};
            F3_H:    data = {2{wd[15:0]}};
            F3_W:    data = wd;
            default: data = 32'h0000_0000;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Purely combinational lane selection and sign/zero extension of a read word.
// Ports:
//   mem_rdata  in  32  raw word returned by memory
//   addr       in  2   byte offset of the access within the word
//   funct3     in  3   access size / signedness
//   load_data  out 32  extended load result
// -----------------------------------------------------------------------------
module load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword lanes out of the read word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (addr)
            2'b00:   byte_s = mem_rdata[7:0];
            2'b01:   byte_s = mem_rdata[15:8];
            2'b10:   byte_s = mem_rdata[23:16];
            2'b11:   byte_s = mem_rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = mem_rdata[31:16];
        end else begin
            half_s = mem_rdata[15:0];
        end
    end

    // Extend the selected lane according to size and signedness.
    always_comb begin
        load_data = 32'h0000_0000;
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_W:    load_data = mem_rdata;
            F3_BU:   load_data = {24'h00_0000, byte_s};
            F3_HU:   load_data = {16'h0000, half_s};
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Multi-cycle load/store unit between the execute stage and a handshaked data
// memory. One access at a time: IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
// Illegal or misaligned accesses skip the memory entirely (IDLE -> DONE) and
// raise a one-cycle Fault in DONE.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   MemRead/MemWrite   load / store request, held by the core while Stall=1
//   funct3             access size / signedness
//   ALUres             byte address
//   WriteData          right-aligned store data
//   ReadData           extended load result, valid from DONE until next load
//   Stall              core must hold its state
//   Fault              one-cycle pulse for a suppressed access
//   mem_req/we/addr/wstrb/wdata   memory request (registered)
//   mem_gnt            request accepted
//   mem_rvalid/rdata   read response
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] ALUres,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              Fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t  state_r;
    logic [1:0]  addr_lo_r;
    logic [2:0]  f3_r;
    logic        load_r;

    logic        req_s;
    logic        fault_s;
    logic [31:0] ext_data_s;

    assign req_s   = MemRead | MemWrite;
    // Fault decision is made on the live request in IDLE, before anything is issued.
    assign fault_s = ~access_legal(MemWrite, funct3) | access_misaligned(funct3, ALUres[1:0]);

    // The core only has to wait while an access is in flight; DONE releases it.
    assign Stall = req_s & (state_r != DONE);

    load_extract u_load_extract (
        .mem_rdata (mem_rdata),
        .addr      (addr_lo_r),
        .funct3    (f3_r),
        .load_data (ext_data_s)
    );

    // Access sequencer with registered memory-side outputs, ReadData and Fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            addr_lo_r <= 2'b00;
            f3_r      <= 3'b000;
            load_r    <= 1'b0;
            ReadData  <= 32'h0000_0000;
            Fault     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    Fault <= 1'b0;
                    if (req_s) begin
                        addr_lo_r <= ALUres[1:0];
                        f3_r      <= funct3;
                        load_r    <= MemRead;
                        if (fault_s) begin
                            // Memory-side registers are left untouched so nothing toggles.
                            state_r <= DONE;
                            Fault   <= 1'b1;
                        end else begin
                            state_r  <= REQ;
                            mem_req  <= 1'b1;
                            mem_we   <= MemWrite;
                            mem_addr <= {ALUres[ADDR_W-1:2], 2'b00};
                            if (MemWrite) begin
                                mem_wstrb <= store_wstrb(funct3, ALUres[1:0]);
                                mem_wdata <= store_wdata(funct3, WriteData);
                            end else begin
                                mem_wstrb <= 4'b0000;
                            end
                        end
                    end
                end
                REQ: begin
                    // Request fields are held until the memory accepts them.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= load_r ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        ReadData <= ext_data_s;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    // Request inputs now belong to the next instruction; always go idle.
                    Fault   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    Fault   <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed-vector bench for load_store_unit with a small word-addressed
// memory model and hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUres;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks;
    int n_pass;

    logic [31:0] mem_model [int unsigned];

    // Results of the most recent access
    int          acc_stalls;
    int          acc_faults;
    int          acc_reqs;
    int          acc_first_req;
    logic        acc_stable;
    logic        acc_done;
    logic [31:0] acc_rd;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_we;
    logic [3:0]  acc_strb;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .ALUres     (ALUres),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .Stall      (Stall),
        .Fault      (Fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int unsigned k;
        k = a;
        if (mem_model.exists(k)) return mem_model[k];
        return 32'h0000_0000;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] wd);
        logic [31:0] w;
        int unsigned k;
        w = model_rd(a);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) w[8*b +: 8] = wd[8*b +: 8];
        end
        k = a;
        mem_model[k] = w;
    endtask

    // Runs one access from the IDLE cycle through DONE, acting as the memory.
    // Entered and left #1 after a rising edge.
    task automatic do_access(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int gnt_wait, input int rv_wait);
        int  gcnt;
        int  rv_left;
        logic rv_armed;
        logic [31:0] rd_addr;
        MemRead   = ld;
        MemWrite  = st;
        funct3    = f3;
        ALUres    = addr;
        WriteData = wd;
        acc_stalls = 0; acc_faults = 0; acc_reqs = 0; acc_first_req = -1;
        acc_stable = 1'b1; acc_done = 1'b0;
        gcnt = 0; rv_left = 0; rv_armed = 1'b0; rd_addr = 32'h0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (Stall) acc_stalls++;
            if (Fault) acc_faults++;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (rv_armed) begin
                if (rv_left == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = model_rd(rd_addr);
                    rv_armed   = 1'b0;
                end else begin
                    rv_left--;
                end
            end
            if (mem_req) begin
                if (acc_reqs == 0) begin
                    acc_first_req = cyc;
                    acc_addr  = mem_addr;
                    acc_we    = mem_we;
                    acc_strb  = mem_wstrb;
                    acc_wdata = mem_wdata;
                end else if (mem_addr !== acc_addr || mem_we !== acc_we ||
                             mem_wstrb !== acc_strb || mem_wdata !== acc_wdata) begin
                    acc_stable = 1'b0;
                end
                acc_reqs++;
                if (gcnt == gnt_wait) begin
                    mem_gnt = 1'b1;
                    if (mem_we) begin
                        model_wr(mem_addr, mem_wstrb, mem_wdata);
                    end else begin
                        rd_addr  = mem_addr;
                        rv_armed = 1'b1;
                        rv_left  = rv_wait;
                    end
                end else begin
                    gcnt++;
                end
            end
            if (!Stall) begin
                acc_done = 1'b1;
                acc_rd   = ReadData;
                break;
            end
        end
        @(posedge clk);
        #1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check_value("access_completes", {31'd0, acc_done}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
        ALUres = 32'h0; WriteData = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        mem_model[32'h1000] = 32'h80FF_1234;
        mem_model[32'h2000] = 32'h9ABC_0000;
        mem_model[32'h4000] = 32'h1357_9BDF;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_value("rst_readdata", ReadData, 32'h0);
        check_value("rst_fault",    {31'd0, Fault}, 32'd0);
        check_value("rst_stall",    {31'd0, Stall}, 32'd0);
        check_value("rst_req",      {31'd0, mem_req}, 32'd0);
        check_value("rst_we",       {31'd0, mem_we}, 32'd0);
        check_value("rst_wstrb",    {28'd0, mem_wstrb}, 32'd0);
        check_value("rst_addr",     mem_addr, 32'h0);
        check_value("rst_wdata",    mem_wdata, 32'h0);
        @(posedge clk); #1;

        // LB, sign-extended top lane, zero-wait memory
        do_access(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 0, 0);
        check_value("lb_data",   acc_rd, 32'hFFFF_FF80);
        check_value("lb_addr",   acc_addr, 32'h1000);
        check_value("lb_stalls", acc_stalls, 3);
        check_value("lb_faults", acc_faults, 0);
        check_value("lb_we",     {31'd0, acc_we}, 32'd0);

        // LHU / LH of the upper half
        do_access(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 0, 0);
        check_value("lhu_data", acc_rd, 32'h0000_9ABC);
        do_access(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 0, 0);
        check_value("lh_data",  acc_rd, 32'hFFFF_9ABC);

        // SB with grant withheld for two cycles
        do_access(1'b0, 1'b1, 3'b000, 32'h3001, 32'h0000_00A5, 2, 0);
        check_value("sb_we",     {31'd0, acc_we}, 32'd1);
        check_value("sb_wstrb",  {28'd0, acc_strb}, 32'h2);
        check_value("sb_wdata",  acc_wdata, 32'hA5A5_A5A5);
        check_value("sb_addr",   acc_addr, 32'h3000);
        check_value("sb_stalls", acc_stalls, 4);
        check_value("sb_stable", {31'd0, acc_stable}, 32'd1);
        check_value("sb_mem",    model_rd(32'h3000), 32'h0000_A500);

        // Misaligned LW: fault, no request, ReadData unchanged
        do_access(1'b1, 1'b0, 3'b010, 32'h4002, 32'h0, 0, 0);
        check_value("lw_mis_fault",  acc_faults, 1);
        check_value("lw_mis_reqs",   acc_reqs, 0);
        check_value("lw_mis_stalls", acc_stalls, 1);
        check_value("lw_mis_rd",     acc_rd, 32'hFFFF_9ABC);
        check_value("lw_mis_pulse",  {31'd0, Fault}, 32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 0, 0);
        check_value("lw_ok_data",   acc_rd, 32'h1357_9BDF);
        check_value("lw_ok_stalls", acc_stalls, 3);
        check_value("lw_ok_faults", acc_faults, 0);

        // Illegal encodings and misaligned halfword
        do_access(1'b0, 1'b1, 3'b100, 32'h0020, 32'h1234_5678, 0, 0);
        check_value("sbu_illegal_fault", acc_faults, 1);
        check_value("sbu_illegal_reqs",  acc_reqs, 0);
        do_access(1'b1, 1'b0, 3'b011, 32'h0020, 32'h0, 0, 0);
        check_value("ld011_illegal_fault", acc_faults, 1);
        do_access(1'b1, 1'b0, 3'b001, 32'h0011, 32'h0, 0, 0);
        check_value("lh_mis_fault", acc_faults, 1);
        check_value("lh_mis_rd",    acc_rd, 32'h1357_9BDF);

        // Back-to-back SW then LW
        do_access(1'b0, 1'b1, 3'b010, 32'h0010, 32'hCAFE_F00D, 0, 0);
        check_value("sw_stalls", acc_stalls, 2);
        check_value("sw_wstrb",  {28'd0, acc_strb}, 32'hF);
        do_access(1'b1, 1'b0, 3'b010, 32'h0010, 32'h0, 0, 0);
        check_value("b2b_first_req", acc_first_req, 1);
        check_value("b2b_data",      acc_rd, 32'hCAFE_F00D);

        // SH to upper half, then LBU and a slow LHU
        do_access(1'b0, 1'b1, 3'b001, 32'h0012, 32'h1234_BEEF, 0, 0);
        check_value("sh_wdata", acc_wdata, 32'hBEEF_BEEF);
        check_value("sh_wstrb", {28'd0, acc_strb}, 32'hC);
        do_access(1'b1, 1'b0, 3'b100, 32'h0013, 32'h0, 0, 0);
        check_value("lbu_data", acc_rd, 32'h0000_00BE);
        do_access(1'b1, 1'b0, 3'b101, 32'h0010, 32'h0, 0, 2);
        check_value("lhu_slow_data",   acc_rd, 32'h0000_F00D);
        check_value("lhu_slow_stalls", acc_stalls, 5);

        // Reset while waiting for read data, then a stray rvalid
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUres = 32'h4000;
        @(negedge clk);                       // IDLE
        @(negedge clk);                       // REQ
        check_value("rstw_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);                       // WAIT
        mem_gnt = 1'b0;
        rst     = 1'b1;
        MemRead = 1'b0;
        @(posedge clk); #1;
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        check_value("rstw_readdata", ReadData, 32'h0);
        check_value("rstw_req_low",  {31'd0, mem_req}, 32'd0);
        check_value("rstw_stall",    {31'd0, Stall}, 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_value("rstw_stray_rvalid", ReadData, 32'h0);
        @(posedge clk); #1;

        // Recovery after reset
        do_access(1'b1, 1'b0, 3'b100, 32'h1000, 32'h0, 0, 0);
        check_value("post_rst_lbu", acc_rd, 32'h0000_0034);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
